mat_mult_seq: RTL and testbench

Parametrised sequential N×N matrix engine, successor to the fixed 6×6 multiplier/accumulator. It computes either C = A·B by column/row outer-product accumulation over N issue cycles, or an element-wise product in a single issue. It uses a start/ready request handshake and a valid/ready result handshake. It sits between the Avalon register front end and the IK solver datapath, and captures its operands internally so the front end may change them once a start is accepted.

---
 rtl/mat_mult_seq.sv | 182 ++++++++++++++++++
 tb/tb_mat_mult_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mult_seq.sv
// Sequential NxN matrix engine: outer-product matrix multiply over N issue cycles, or element-wise product.
// Optional MAT_MULT_SAT_EN: rescale by W/2 and saturate on narrowing; otherwise wrap to the low W bits.
module mat_mult_seq #(
    parameter int N = 6,
    parameter int W = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    output logic             start_ready,
    input  logic [N*N*W-1:0] dataa,
    input  logic [N*N*W-1:0] datab,
    output logic [N*N*W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int KW = $clog2(N);
    localparam int PW = 2 * W;
    localparam int AW = 2 * W + $clog2(N);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [KW-1:0]        k;
    logic                 mode_r;
    logic signed [W-1:0]  a_r [N][N];
    logic signed [W-1:0]  b_r [N][N];
    logic signed [PW-1:0] p_p0 [N][N];
    logic                 vld_p0;
    logic                 first_p0;
    logic                 last_p0;
    logic signed [AW-1:0] acc_p1 [N][N];
    logic                 last_p1;

    logic accept;
    logic issue;
    logic last_issue;

    function automatic logic signed [PW-1:0] mul_full(input logic signed [W-1:0] x,
                                                      input logic signed [W-1:0] y);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ye;
        xe = PW'(x);
        ye = PW'(y);
        return xe * ye;
    endfunction

    function automatic logic signed [AW-1:0] ext_acc(input logic signed [PW-1:0] v);
        return AW'(v);
    endfunction

`ifdef MAT_MULT_SAT_EN
    localparam logic signed [W-1:0] MAX_W = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};

    // Fixed-point rescale by W/2 fractional bits, then clamp into the signed W-bit range.
    function automatic logic signed [W-1:0] narrow(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] s;
        logic signed [AW-1:0] hi;
        logic signed [AW-1:0] lo;
        s  = v >>> (W / 2);
        hi = AW'(MAX_W);
        lo = AW'(MIN_W);
        if (s > hi)
            return MAX_W;
        else if (s < lo)
            return MIN_W;
        else
            return W'(s);
    endfunction
`else
    function automatic logic signed [W-1:0] narrow(input logic signed [AW-1:0] v);
        return W'(v);
    endfunction
`endif

    assign accept     = start && start_ready && en;
    assign issue      = (state == ISSUE);
    assign last_issue = issue && (!mode_r || (k == KW'(N - 1)));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = ISSUE;
            ISSUE: if (en && last_issue) state_next = DRAIN;
            DRAIN: if (en && last_p1) state_next = DONE;
            DONE:  if (en && result_valid && result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured once at accept so the front end may change them afterwards.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_r[i][j] <= dataa[(i*N+j)*W +: W];
                    b_r[i][j] <= datab[(i*N+j)*W +: W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            start_ready  <= 1'b1;
            result_valid <= 1'b0;
            k            <= '0;
            mode_r       <= 1'b0;
        end else if (en) begin
            state        <= state_next;
            start_ready  <= (state_next == IDLE);
            result_valid <= (state_next == DONE);
            if (accept) begin
                mode_r <= mode;
                k      <= '0;
            end else if (issue && mode_r) begin
                k <= k + KW'(1);
            end
        end
    end

    // Stage p0: one product per element per issue cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0   <= 1'b0;
            first_p0 <= 1'b0;
            last_p0  <= 1'b0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    p_p0[i][j] <= '0;
        end else if (en) begin
            vld_p0   <= issue;
            first_p0 <= issue && (k == '0);
            last_p0  <= last_issue;
            if (issue) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        if (mode_r)
                            p_p0[i][j] <= mul_full(a_r[i][k], b_r[k][j]);
                        else
                            p_p0[i][j] <= mul_full(a_r[i][j], b_r[i][j]);
                    end
                end
            end
        end
    end

    // Stage p1: accumulate; the k = 0 product restarts each element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_p1 <= 1'b0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    acc_p1[i][j] <= '0;
        end else if (en) begin
            last_p1 <= vld_p0 && last_p0;
            if (vld_p0) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        acc_p1[i][j] <= (first_p0 ? '0 : acc_p1[i][j]) + ext_acc(p_p0[i][j]);
            end
        end
    end

    // Output stage: narrow the finished accumulators; result holds until the next run completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
        end else if (en && (state == DRAIN) && last_p1) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    result[(i*N+j)*W +: W] <= narrow(acc_p1[i][j]);
        end
    end

endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed self-checking bench for mat_mult_seq (N = 6, W = 36); saturation vectors when MAT_MULT_SAT_EN is defined.
module tb_mat_mult_seq;

    localparam int N  = 6;
    localparam int W  = 36;
    localparam int NW = N * N * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic          mode = 1'b0;
    logic          start = 1'b0;
    logic          start_ready;
    logic [NW-1:0] dataa = '0;
    logic [NW-1:0] datab = '0;
    logic [NW-1:0] result;
    logic          result_valid;
    logic          result_ready = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    logic [NW-1:0] a_v;
    logic [NW-1:0] b_v;
    logic [NW-1:0] c_v;
    int            lat;
    int            sr_hi;

    mat_mult_seq #(.N(N), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode         (mode),
        .start        (start),
        .start_ready  (start_ready),
        .dataa        (dataa),
        .datab        (datab),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NW-1:0] put(input logic [NW-1:0] v, input int i, input int j,
                                          input longint x);
        logic [W-1:0] e;
        e = W'(x);
        v[(i*N+j)*W +: W] = e;
        return v;
    endfunction

    function automatic logic [W-1:0] el(input logic [NW-1:0] v, input int i, input int j);
        return v[(i*N+j)*W +: W];
    endfunction

    task automatic check_c(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s[%0d][%0d]", tag, i, j), 64'(el(result, i, j)), 64'(el(c_v, i, j)));
    endtask

    // Start a run from a_v/b_v, then scramble the operand inputs and wait for result_valid.
    task automatic run(input logic md, input int stall_at, input int stall_len, input int pulse_at,
                       output int lat_o, output int sr_o);
        dataa = a_v;
        datab = b_v;
        mode  = md;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = ~md;
        dataa = ~a_v;
        datab = ~b_v;
        lat_o = 0;
        sr_o  = 0;
        while (lat_o < 60) begin
            if (lat_o == stall_at) en = 1'b0;
            if (lat_o == stall_at + stall_len) en = 1'b1;
            start = (lat_o == pulse_at);
            @(posedge clk);
            #1;
            lat_o++;
            if (start_ready) sr_o++;
            if (result_valid) break;
        end
        start = 1'b0;
        en    = 1'b1;
    endtask

    task automatic handshake(input string tag, input int hold);
        logic [NW-1:0] snap;
        snap = result;
        result_ready = 1'b0;
        for (int n = 0; n < hold; n++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 64'(result_valid), 64'd1);
            check({tag, "_hold_stable"}, 64'(result === snap), 64'd1);
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check({tag, "_hs_valid"}, 64'(result_valid), 64'd0);
        check({tag, "_hs_ready"}, 64'(start_ready), 64'd1);
        check({tag, "_hs_keep"}, 64'(result === snap), 64'd1);
    endtask

    initial begin
        #12;
        check("rst_result", 64'(|result), 64'd0);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_start_ready", 64'(start_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef MAT_MULT_SAT_EN
        a_v = '0; b_v = '0; c_v = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_v = put(a_v, i, j, 64'sh4_0000_0000);
                b_v = put(b_v, i, j, 64'sh4_0000_0000);
                c_v = put(c_v, i, j, 64'sh7_FFFF_FFFF);
            end
        run(1'b1, -1, 0, -1, lat, sr_hi);
        check("sat_hi_latency", 64'(lat), 64'd8);
        check_c("sat_hi");
        handshake("sat_hi", 1);

        a_v = '0; b_v = '0; c_v = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_v = put(a_v, i, j, 64'sh2_0000);
                b_v = put(b_v, i, j, 64'sh2_0000);
                c_v = put(c_v, i, j, 64'sh6_0000);
            end
        run(1'b1, -1, 0, -1, lat, sr_hi);
        check("sat_half_latency", 64'(lat), 64'd8);
        check_c("sat_half");
        handshake("sat_half", 1);
`else
        a_v = '0; b_v = '0; c_v = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_v = put(a_v, i, j, (i == j) ? 1 : 0);
                b_v = put(b_v, i, j, 10 * i + j);
                c_v = put(c_v, i, j, 10 * i + j);
            end
        run(1'b1, -1, 0, -1, lat, sr_hi);
        check("ident_latency", 64'(lat), 64'd8);
        check("ident_start_ready_low", 64'(sr_hi), 64'd0);
        check_c("ident");
        handshake("ident", 1);

        a_v = '0; b_v = '0; c_v = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_v = put(a_v, i, j, i + 1);
                b_v = put(b_v, i, j, j + 1);
                c_v = put(c_v, i, j, 6 * (i + 1) * (j + 1));
            end
        run(1'b1, -1, 0, -1, lat, sr_hi);
        check("count_latency", 64'(lat), 64'd8);
        check("count_c55", 64'(el(result, 5, 5)), 64'd216);
        check_c("count");
        handshake("count", 1);

        a_v = '0; b_v = '0; c_v = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_v = put(a_v, i, j, -1);
                b_v = put(b_v, i, j, 1);
                c_v = put(c_v, i, j, 64'hF_FFFF_FFFA);
            end
        run(1'b1, -1, 0, -1, lat, sr_hi);
        check_c("neg");
        handshake("neg", 1);

        a_v = '0; b_v = '0; c_v = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_v = put(a_v, i, j, 3);
                b_v = put(b_v, i, j, -7);
                c_v = put(c_v, i, j, -21);
            end
        run(1'b0, -1, 0, 1, lat, sr_hi);
        check("elem_latency", 64'(lat), 64'd3);
        check("elem_start_ready_low", 64'(sr_hi), 64'd0);
        check_c("elem");
        handshake("elem", 1);
        check("elem_no_queue_valid", 64'(result_valid), 64'd0);

        a_v = '0; b_v = '0; c_v = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_v = put(a_v, i, j, i + 1);
                b_v = put(b_v, i, j, j + 1);
                c_v = put(c_v, i, j, 6 * (i + 1) * (j + 1));
            end
        run(1'b1, 3, 3, -1, lat, sr_hi);
        check("stall_latency", 64'(lat), 64'd11);
        check_c("stall");
        handshake("stall", 5);

        // Abort a run with reset at k = 3; result from the previous run must be cleared.
        a_v = '0; b_v = '0; c_v = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_v = put(a_v, i, j, (i == j) ? 1 : 0);
                b_v = put(b_v, i, j, 10 * i + j);
                c_v = put(c_v, i, j, 10 * i + j);
            end
        dataa = a_v;
        datab = b_v;
        mode  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_result", 64'(|result), 64'd0);
        check("midrst_valid", 64'(result_valid), 64'd0);
        check("midrst_start_ready", 64'(start_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_valid", 64'(result_valid), 64'd0);
        check("postrst_start_ready", 64'(start_ready), 64'd1);
        run(1'b1, -1, 0, -1, lat, sr_hi);
        check("postrst_latency", 64'(lat), 64'd8);
        check_c("postrst");
        handshake("postrst", 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
